// File: rtl/fp_align_swap.sv
// fp_align_swap: two-stage operand alignment front end for a floating-point adder.
//   Stage S1 orders the operand pair by magnitude. It registers the larger and the
//   smaller significand (hidden bit restored), the larger effective exponent, the
//   exponent difference and the sign and special flags.
//   Stage S2 shifts the smaller significand right by the exponent difference and
//   produces guard, round and sticky bits.
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   in_valid/in_ready      input handshake for the operand pair in_a, in_b
//   out_valid/out_ready    output handshake for the result
//   out_big_sign           sign of the larger-magnitude operand
//   out_big_exp            effective exponent of the larger operand
//   out_big_sig            larger significand, hidden bit included
//   out_small_sig          smaller significand aligned to out_big_exp
//   out_grs                guard/round/sticky bits (bit 2 = guard)
//   out_swapped            in_b was the larger operand
//   out_sign_differ        the operand signs differ
//   out_special            either operand has an all-ones exponent
module fp_align_swap #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] in_a,
   input  logic [EXP_W+MAN_W:0] in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_big_sign,
   output logic [EXP_W-1:0]     out_big_exp,
   output logic [MAN_W:0]       out_big_sig,
   output logic [MAN_W:0]       out_small_sig,
   output logic [2:0]           out_grs,
   output logic                 out_swapped,
   output logic                 out_sign_differ,
   output logic                 out_special
);

   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SIG_W = MAN_W + 1;
   localparam int unsigned SH_W  = MAN_W + 3;  // significand plus guard and round positions
   localparam int unsigned FR_W  = 2 * SH_W;   // room below round for every bit a shift can push out

   function automatic logic [EXP_W-1:0] eff_exp(input logic [W-1:0] op);
      return (op[W-2:MAN_W] == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : op[W-2:MAN_W];
   endfunction

   function automatic logic [SIG_W-1:0] sig_of(input logic [W-1:0] op);
      return {op[W-2:MAN_W] != '0, op[MAN_W-1:0]};
   endfunction

   // S1 state
   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_big_sign_q, s1_big_sign_d;
   logic [EXP_W-1:0]     s1_big_exp_q, s1_big_exp_d;
   logic [SIG_W-1:0]     s1_big_sig_q, s1_big_sig_d;
   logic [SIG_W-1:0]     s1_small_sig_q, s1_small_sig_d;
   logic [EXP_W-1:0]     s1_diff_q, s1_diff_d;
   logic                 s1_swapped_q, s1_swapped_d;
   logic                 s1_sign_differ_q, s1_sign_differ_d;
   logic                 s1_special_q, s1_special_d;

   // S2 state (drives the outputs directly)
   logic                 out_valid_q, out_valid_d;
   logic                 out_big_sign_q, out_big_sign_d;
   logic [EXP_W-1:0]     out_big_exp_q, out_big_exp_d;
   logic [SIG_W-1:0]     out_big_sig_q, out_big_sig_d;
   logic [SIG_W-1:0]     out_small_sig_q, out_small_sig_d;
   logic [2:0]           out_grs_q, out_grs_d;
   logic                 out_swapped_q, out_swapped_d;
   logic                 out_sign_differ_q, out_sign_differ_d;
   logic                 out_special_q, out_special_d;

   logic                 swap;
   logic [W-1:0]         big_op, small_op;
   logic                 s1_load, s2_load;
   logic [FR_W-1:0]      frame;
   logic [SIG_W-1:0]     sh_sig;
   logic [2:0]           sh_grs;

   always_comb begin
      // Ties keep in_a as the larger operand.
      swap     = in_b[W-2:0] > in_a[W-2:0];
      big_op   = swap ? in_b : in_a;
      small_op = swap ? in_a : in_b;

      // Alignment shift. Bits pushed past round stay inside the frame, so sticky is an OR over its low half.
      frame = {s1_small_sig_q, 2'b00, {SH_W{1'b0}}} >> s1_diff_q;
      if (32'(s1_diff_q) >= SH_W) begin
         sh_sig = '0;
         sh_grs = {2'b00, |s1_small_sig_q};
      end else begin
         sh_sig = frame[FR_W-1 -: SIG_W];
         sh_grs = {frame[SH_W+1], frame[SH_W], |frame[SH_W-1:0]};
      end

      s2_load  = s1_valid_q && (!out_valid_q || out_ready);
      in_ready = !s1_valid_q || s2_load;
      s1_load  = in_valid && in_ready;

      s1_valid_d       = s1_load || (s1_valid_q && !s2_load);
      s1_big_sign_d    = s1_big_sign_q;
      s1_big_exp_d     = s1_big_exp_q;
      s1_big_sig_d     = s1_big_sig_q;
      s1_small_sig_d   = s1_small_sig_q;
      s1_diff_d        = s1_diff_q;
      s1_swapped_d     = s1_swapped_q;
      s1_sign_differ_d = s1_sign_differ_q;
      s1_special_d     = s1_special_q;
      if (s1_load) begin
         s1_big_sign_d    = big_op[W-1];
         s1_big_exp_d     = eff_exp(big_op);
         s1_big_sig_d     = sig_of(big_op);
         s1_small_sig_d   = sig_of(small_op);
         s1_diff_d        = eff_exp(big_op) - eff_exp(small_op);
         s1_swapped_d     = swap;
         s1_sign_differ_d = in_a[W-1] ^ in_b[W-1];
         s1_special_d     = (&in_a[W-2:MAN_W]) || (&in_b[W-2:MAN_W]);
      end

      out_valid_d       = s2_load || (out_valid_q && !out_ready);
      out_big_sign_d    = out_big_sign_q;
      out_big_exp_d     = out_big_exp_q;
      out_big_sig_d     = out_big_sig_q;
      out_small_sig_d   = out_small_sig_q;
      out_grs_d         = out_grs_q;
      out_swapped_d     = out_swapped_q;
      out_sign_differ_d = out_sign_differ_q;
      out_special_d     = out_special_q;
      if (s2_load) begin
         out_big_sign_d    = s1_big_sign_q;
         out_big_exp_d     = s1_big_exp_q;
         out_big_sig_d     = s1_big_sig_q;
         out_small_sig_d   = sh_sig;
         out_grs_d         = sh_grs;
         out_swapped_d     = s1_swapped_q;
         out_sign_differ_d = s1_sign_differ_q;
         out_special_d     = s1_special_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q        <= 1'b0;
         s1_big_sign_q     <= 1'b0;
         s1_big_exp_q      <= '0;
         s1_big_sig_q      <= '0;
         s1_small_sig_q    <= '0;
         s1_diff_q         <= '0;
         s1_swapped_q      <= 1'b0;
         s1_sign_differ_q  <= 1'b0;
         s1_special_q      <= 1'b0;
         out_valid_q       <= 1'b0;
         out_big_sign_q    <= 1'b0;
         out_big_exp_q     <= '0;
         out_big_sig_q     <= '0;
         out_small_sig_q   <= '0;
         out_grs_q         <= '0;
         out_swapped_q     <= 1'b0;
         out_sign_differ_q <= 1'b0;
         out_special_q     <= 1'b0;
      end else begin
         s1_valid_q        <= s1_valid_d;
         s1_big_sign_q     <= s1_big_sign_d;
         s1_big_exp_q      <= s1_big_exp_d;
         s1_big_sig_q      <= s1_big_sig_d;
         s1_small_sig_q    <= s1_small_sig_d;
         s1_diff_q         <= s1_diff_d;
         s1_swapped_q      <= s1_swapped_d;
         s1_sign_differ_q  <= s1_sign_differ_d;
         s1_special_q      <= s1_special_d;
         out_valid_q       <= out_valid_d;
         out_big_sign_q    <= out_big_sign_d;
         out_big_exp_q     <= out_big_exp_d;
         out_big_sig_q     <= out_big_sig_d;
         out_small_sig_q   <= out_small_sig_d;
         out_grs_q         <= out_grs_d;
         out_swapped_q     <= out_swapped_d;
         out_sign_differ_q <= out_sign_differ_d;
         out_special_q     <= out_special_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_big_sign    = out_big_sign_q;
   assign out_big_exp     = out_big_exp_q;
   assign out_big_sig     = out_big_sig_q;
   assign out_small_sig   = out_small_sig_q;
   assign out_grs         = out_grs_q;
   assign out_swapped     = out_swapped_q;
   assign out_sign_differ = out_sign_differ_q;
   assign out_special     = out_special_q;

endmodule

// File: tb/tb_fp_align_swap.sv
// tb_fp_align_swap: bench for fp_align_swap (EXP_W=8, MAN_W=23).
//   A reference model computes each result from the operand values with plain
//   integer arithmetic. A queue holds the pairs accepted but not yet delivered,
//   and one compare process checks the DUT against the oldest entry every cycle.
//   Hand-computed literal results travel with selected pairs and pin the model.
module tb_fp_align_swap;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SIG_W = MAN_W + 1;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] big_sig;
      logic [SIG_W-1:0] small_sig;
      logic [2:0]       grs;
      logic             swapped;
      logic             sign_differ;
      logic             special;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         pinned;
      res_t         pin;
      int           acc_cyc;
      bit           clean;
      bit           seen;
   } txn_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_a = '0;
   logic [W-1:0]     in_b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_big_sign;
   logic [EXP_W-1:0] out_big_exp;
   logic [SIG_W-1:0] out_big_sig;
   logic [SIG_W-1:0] out_small_sig;
   logic [2:0]       out_grs;
   logic             out_swapped;
   logic             out_sign_differ;
   logic             out_special;

   logic             pin_en = 1'b0;
   res_t             pin_val = '0;
   bit               stim_timeout = 1'b0;
   bit               done = 1'b0;
   res_t             dut_r;

   fp_align_swap #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_big_sign(out_big_sign), .out_big_exp(out_big_exp),
      .out_big_sig(out_big_sig), .out_small_sig(out_small_sig),
      .out_grs(out_grs), .out_swapped(out_swapped),
      .out_sign_differ(out_sign_differ), .out_special(out_special)
   );

   always #5 clk = ~clk;

   assign dut_r = {out_big_sign, out_big_exp, out_big_sig, out_small_sig,
                   out_grs, out_swapped, out_sign_differ, out_special};

   // Reference: value-level description of magnitude ordering and alignment.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t            r;
      logic [W-1:0]    bg, sm;
      bit              b_bigger;
      int unsigned     eb, es, d;
      longint unsigned sig_b, sig_s, x, y, lost;
      b_bigger = 64'(b[W-2:0]) > 64'(a[W-2:0]);
      bg = b_bigger ? b : a;
      sm = b_bigger ? a : b;
      eb = 32'(bg[W-2:MAN_W]);
      es = 32'(sm[W-2:MAN_W]);
      sig_b = 64'(bg[MAN_W-1:0]) + ((eb != 0) ? (64'd1 << MAN_W) : 64'd0);
      sig_s = 64'(sm[MAN_W-1:0]) + ((es != 0) ? (64'd1 << MAN_W) : 64'd0);
      if (eb == 0) eb = 1;
      if (es == 0) es = 1;
      d = eb - es;
      if (d >= MAN_W + 3) begin
         r.small_sig = '0;
         r.grs = {2'b00, sig_s != 0};
      end else begin
         x = sig_s << 2;
         y = x >> d;
         lost = x & ((64'd1 << d) - 64'd1);
         r.small_sig = SIG_W'(y >> 2);
         r.grs = {y[1], y[0], lost != 0};
      end
      r.sign        = bg[W-1];
      r.exp         = EXP_W'(eb);
      r.big_sig     = SIG_W'(sig_b);
      r.swapped     = b_bigger;
      r.sign_differ = a[W-1] != b[W-1];
      r.special     = (a[W-2:MAN_W] == '1) || (b[W-2:MAN_W] == '1);
      return r;
   endfunction

   function automatic res_t mk(input logic s, input logic [7:0] e, input logic [23:0] bs,
                               input logic [23:0] ss, input logic [2:0] g,
                               input logic sw, input logic sd, input logic sp);
      return {s, e, bs, ss, g, sw, sd, sp};
   endfunction

   // Compare process
   txn_t q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   res_t m;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   always @(negedge clk or negedge rst_n) begin
      #1;
      if (!rst_n) begin
         check("rst_in_ready", 64'(in_ready), 64'd1);
         check("rst_out_valid", 64'(out_valid), 64'd0);
         check("rst_outputs", 64'(dut_r), 64'd0);
         q.delete();
      end else begin
         cyc++;
         if (cyc > 5000) begin
            n_fail++;
            $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required done", cyc);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
         if (done) begin
            check("drained", 64'(q.size()), 64'd0);
            check("stim_timeout", 64'(stim_timeout), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
         end
         // Two pairs fill the pipe; a full pipe accepts only when the head leaves.
         check("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
         if (q.size() == 0) begin
            check("idle_out_valid", 64'(out_valid), 64'd0);
         end else if (out_valid) begin
            m = model(q[0].a, q[0].b);
            check("result", 64'(dut_r), 64'(m));
            if (q[0].pinned) check("pinned", 64'(dut_r), 64'(q[0].pin));
            if (!q[0].seen) begin
               q[0].seen = 1'b1;
               if (q[0].clean) check("latency", 64'(cyc - q[0].acc_cyc), 64'd2);
            end
         end
         if (!out_ready) foreach (q[i]) q[i].clean = 1'b0;
         if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready)
            q.push_back('{a: in_a, b: in_b, pinned: pin_en, pin: pin_val,
                          acc_cyc: cyc, clean: out_ready, seen: 1'b0});
      end
   end

   // Stimulus
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic pe, input res_t pv);
      bit ok = 1'b0;
      in_a = a; in_b = b; pin_en = pe; pin_val = pv; in_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) stim_timeout = 1'b1;
      in_valid = 1'b0; pin_en = 1'b0;
   endtask

   logic [W-1:0] va[9];
   logic [W-1:0] vb[9];
   res_t         vr[9];

   task automatic send_vec(input int unsigned k);
      send(va[k], vb[k], 1'b1, vr[k]);
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      va[0] = 32'h3F800000; vb[0] = 32'h40000000; vr[0] = mk(0, 8'h80, 24'h800000, 24'h400000, 3'b000, 1, 0, 0);
      va[1] = 32'h40400000; vb[1] = 32'hC0400000; vr[1] = mk(0, 8'h80, 24'hC00000, 24'hC00000, 3'b000, 0, 1, 0);
      va[2] = 32'h4B800000; vb[2] = 32'h3F800001; vr[2] = mk(0, 8'h97, 24'h800000, 24'h000000, 3'b101, 0, 0, 0);
      va[3] = 32'h4B800000; vb[3] = 32'h00000001; vr[3] = mk(0, 8'h97, 24'h800000, 24'h000000, 3'b001, 0, 0, 0);
      va[4] = 32'h7F800000; vb[4] = 32'h3F800000; vr[4] = mk(0, 8'hFF, 24'h800000, 24'h000000, 3'b001, 0, 0, 1);
      va[5] = 32'h40000000; vb[5] = 32'h3F800003; vr[5] = mk(0, 8'h80, 24'h800000, 24'h400001, 3'b100, 0, 0, 0);
      va[6] = 32'h40000000; vb[6] = 32'h3E800007; vr[6] = mk(0, 8'h80, 24'h800000, 24'h100000, 3'b111, 0, 0, 0);
      va[7] = 32'h00000003; vb[7] = 32'h00800000; vr[7] = mk(0, 8'h01, 24'h800000, 24'h000003, 3'b000, 1, 0, 0);
      va[8] = 32'h3F800000; vb[8] = 32'hC0000000; vr[8] = mk(1, 8'h80, 24'h800000, 24'h400000, 3'b000, 1, 1, 0);

      idle(2);
      rst_n = 1'b1;
      idle(2);

      // Isolated pairs: exact latency and pinned values.
      for (int unsigned k = 0; k < 9; k++) begin
         send_vec(k);
         idle(3);
      end

      // Back-to-back stream.
      for (int unsigned k = 0; k < 9; k++) send_vec(k);
      idle(4);

      // Stalled output: two pairs are taken, the rest wait, then all four drain in order.
      out_ready = 1'b0;
      fork
         begin
            send_vec(0); send_vec(1); send_vec(5); send_vec(6);
         end
         begin
            idle(8);
            out_ready = 1'b1;
         end
      join
      idle(4);

      // Intermittent back-pressure during a stream.
      fork
         begin
            for (int unsigned k = 0; k < 9; k++) send_vec(8 - k);
         end
         begin
            for (int unsigned c = 0; c < 30; c++) begin
               out_ready = (c % 3) != 1;
               idle(1);
            end
            out_ready = 1'b1;
         end
      join
      idle(5);

      // Reset with two pairs in flight; nothing stale may appear afterwards.
      out_ready = 1'b0;
      send_vec(2);
      send_vec(3);
      #1 rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(4);
      send_vec(4);
      idle(4);
      done = 1'b1;
   end

endmodule
